// File: rtl/hamming_secded_dec.sv
// hamming_secded_dec: two-stage SECDED Hamming decoder with valid/ready flow control.
// Define HAMMING_ECC_ERR_CNT_EN to build the saturating SBE/DBE counters.
module hamming_secded_dec #(
  parameter int DW = 10,
  parameter int PW = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DW-1:0]    i_data,
  input  logic [PW-1:0]    i_parity,
  input  logic             i_par_all,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [DW-1:0]    o_data,
  output logic             o_sbe,
  output logic             o_dbe,
  output logic [PW-1:0]    o_err_pos,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_sbe_cnt,
  output logic [CNT_W-1:0] o_dbe_cnt
);
  localparam int TW = DW + PW;
  if ((1 << PW) < TW + 1) begin : g_bad_pw
    $error("hamming_secded_dec: PW too small for DW");
  end
  localparam logic [PW-1:0] TWL = PW'(TW);
  // codeword position of data bit j: the j-th non-power-of-two position
  function automatic logic [PW-1:0] dpos(input int j);
    int k;
    dpos = '0;
    k = 0;
    for (int q = 1; q <= TW; q++)
      if ((q & (q - 1)) != 0) begin
        if (k == j) dpos = PW'(q);
        k++;
      end
  endfunction
  logic          s1_valid, s1_ovf, ovf0, en1, en2, fix, sbe2, dbe2;
  logic [DW-1:0] s1_data, cd;
  logic [PW-1:0] s1_syn, syn0, pc;
  assign en2 = ~o_valid | i_ready;
  assign en1 = ~s1_valid | en2;
  assign o_ready = en1;
  always_comb begin
    pc = '0;
    for (int j = 0; j < DW; j++) pc = pc ^ ({PW{i_data[j]}} & dpos(j));
    syn0 = i_parity ^ pc;
    ovf0 = i_par_all ^ (^i_data) ^ (^i_parity);
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_syn <= '0;
      s1_ovf <= 1'b0;
    end else if (en1) begin
      s1_valid <= i_valid;
      s1_data <= i_data;
      s1_syn <= syn0;
      s1_ovf <= ovf0;
    end
  always_comb begin
    fix = s1_ovf & (s1_syn != '0) & (s1_syn <= TWL);
    sbe2 = s1_ovf & (s1_syn <= TWL);
    dbe2 = (s1_syn != '0) & ~sbe2;
    for (int j = 0; j < DW; j++) cd[j] = s1_data[j] ^ (fix && s1_syn == dpos(j));
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      o_valid <= 1'b0;
      o_data <= '0;
      o_sbe <= 1'b0;
      o_dbe <= 1'b0;
      o_err_pos <= '0;
    end else if (en2) begin
      o_valid <= s1_valid;
      o_data <= cd;
      o_sbe <= sbe2;
      o_dbe <= dbe2;
      o_err_pos <= fix ? s1_syn : '0;
    end
`ifdef HAMMING_ECC_ERR_CNT_EN
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      o_sbe_cnt <= '0;
      o_dbe_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_sbe_cnt <= '0;
      o_dbe_cnt <= '0;
    end else if (o_valid && i_ready) begin
      if (o_sbe && o_sbe_cnt != '1) o_sbe_cnt <= o_sbe_cnt + 1'b1;
      if (o_dbe && o_dbe_cnt != '1) o_dbe_cnt <= o_dbe_cnt + 1'b1;
    end
`else
  logic unused_clr;
  assign unused_clr = i_clr_cnt;
  assign o_sbe_cnt = '0;
  assign o_dbe_cnt = '0;
`endif
endmodule

// File: tb/tb_hamming_secded_dec.sv
// tb_hamming_secded_dec: random and directed scoreboard bench for hamming_secded_dec.
module tb_hamming_secded_dec;
  localparam int DW = 10, PW = 4, CNT_W = 2, TW = DW + PW;
  localparam int CMAX = (1 << CNT_W) - 1;
  typedef struct packed {
    logic [DW-1:0] d;
    logic          sbe;
    logic          dbe;
    logic [PW-1:0] pos;
  } exp_t;
  logic clk = 0, rst_n = 0, i_valid = 0, i_ready = 0, i_par_all = 0, i_clr_cnt = 0;
  logic o_ready, o_valid, o_sbe, o_dbe;
  logic [DW-1:0] i_data = '0, o_data;
  logic [PW-1:0] i_parity = '0, o_err_pos;
  logic [CNT_W-1:0] o_sbe_cnt, o_dbe_cnt;
  exp_t q[$];
  int errors = 0, checks = 0, m_sbe = 0, m_dbe = 0;
  always #5 clk = ~clk;
  hamming_secded_dec #(.DW(DW), .PW(PW), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rstn(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_parity(i_parity), .i_par_all(i_par_all),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_sbe(o_sbe),
    .o_dbe(o_dbe), .o_err_pos(o_err_pos), .i_clr_cnt(i_clr_cnt),
    .o_sbe_cnt(o_sbe_cnt), .o_dbe_cnt(o_dbe_cnt));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // build the codeword in position order and decode it by XOR of set positions
  function automatic exp_t ref_dec(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic a);
    bit cw[TW+1];
    int j, b, s;
    bit par;
    exp_t e;
    j = 0; b = 0; s = 0; par = a; e = '0;
    for (int k = 1; k <= TW; k++)
      if ((k & (k - 1)) == 0) begin cw[k] = p[b]; b++; end
      else begin cw[k] = d[j]; j++; end
    for (int k = 1; k <= TW; k++)
      if (cw[k]) begin s ^= k; par = ~par; end
    if (par && s <= TW) begin
      e.sbe = 1;
      if (s != 0) begin e.pos = PW'(s); cw[s] = ~cw[s]; end
    end else if (s != 0) e.dbe = 1;
    j = 0;
    for (int k = 1; k <= TW; k++)
      if ((k & (k - 1)) != 0) begin e.d[j] = cw[k]; j++; end
    return e;
  endfunction
  function automatic void enc(input logic [DW-1:0] d, output logic [PW-1:0] p, output logic a);
    int s, j;
    s = 0; j = 0;
    for (int k = 1; k <= TW; k++)
      if ((k & (k - 1)) != 0) begin if (d[j]) s ^= k; j++; end
    p = PW'(s);
    a = ^{d, p};
  endfunction
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [PW-1:0] p, input logic a,
                      input logic rdy, input logic clr, input exp_t e, output logic acc);
    @(negedge clk);
    i_valid = v; i_data = d; i_parity = p; i_par_all = a; i_ready = rdy; i_clr_cnt = clr;
    #1 acc = v && o_ready;
    if (acc) q.push_back(e);
  endtask
  task automatic send(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic a,
                      input exp_t e, input int rdy_pct);
    logic acc;
    acc = 0;
    for (int t = 0; t < 50 && !acc; t++)
      step(1, d, p, a, $urandom_range(99) < rdy_pct, 0, e, acc);
    chk("send_accept", acc, 1);
  endtask
  task automatic idle(input int n, input int rdy_pct, input int clr_pct);
    logic acc;
    repeat (n) step(0, '0, '0, 0, $urandom_range(99) < rdy_pct, $urandom_range(99) < clr_pct, '0, acc);
  endtask
  task automatic drain();
    logic acc;
    for (int t = 0; t < 100 && q.size() != 0; t++) step(0, '0, '0, 0, 1, 0, '0, acc);
    idle(1, 100, 0);
    chk("drain_empty", q.size(), 0);
  endtask
  // monitor: pops the scoreboard on each output handshake and tracks counters
  exp_t held, cur, e;
  bit stalled = 0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      stalled = 0; m_sbe = 0; m_dbe = 0;
    end else begin
      chk("sbe_cnt", o_sbe_cnt, m_sbe);
      chk("dbe_cnt", o_dbe_cnt, m_dbe);
      if (o_valid) begin
        cur = {o_data, o_sbe, o_dbe, o_err_pos};
        if (stalled) chk("stall_hold", cur, held);
        if (i_ready) begin
          if (q.size() == 0) chk("unexpected_out", q.size(), 1);
          else begin
            e = q.pop_front();
            chk("data", o_data, e.d);
            chk("sbe", o_sbe, e.sbe);
            chk("dbe", o_dbe, e.dbe);
            chk("err_pos", o_err_pos, e.pos);
`ifdef HAMMING_ECC_ERR_CNT_EN
            if (e.sbe && m_sbe < CMAX) m_sbe++;
            if (e.dbe && m_dbe < CMAX) m_dbe++;
`endif
          end
        end
        stalled = !i_ready;
        held = cur;
      end else stalled = 0;
`ifdef HAMMING_ECC_ERR_CNT_EN
      if (i_clr_cnt) begin m_sbe = 0; m_dbe = 0; end
`endif
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [DW-1:0] d;
    logic [PW-1:0] p;
    logic a, acc;
    logic [DW+PW:0] v;
    int accepted;
    exp_t sbe_w;
    idle(2, 100, 0);
    chk("rst_ovalid", o_valid, 0);
    chk("rst_oready", o_ready, 1);
    chk("rst_odata", o_data, 0);
    chk("rst_flags", {o_sbe, o_dbe, o_err_pos}, 0);
    chk("rst_cnts", {o_sbe_cnt, o_dbe_cnt}, 0);
    @(negedge clk); #3 rst_n = 1;
    // directed: clean, single data error, double error, overall-parity error
    enc(10'h2A5, p, a);
    send(10'h2A5, p, a, '{d: 10'h2A5, sbe: 0, dbe: 0, pos: 0}, 100);
    send(10'h001, 4'h0, 0, '{d: 10'h000, sbe: 1, dbe: 0, pos: 3}, 100);
    send(10'h003, 4'h0, 0, '{d: 10'h003, sbe: 0, dbe: 1, pos: 0}, 100);
    send(10'h000, 4'h0, 1, '{d: 10'h000, sbe: 1, dbe: 0, pos: 0}, 100);
    drain();
    // random codewords with 0..3 flipped bits, some fully random words
    for (int n = 0; n < 400; n++) begin
      d = DW'($urandom);
      enc(d, p, a);
      v = {a, p, d};
      repeat ($urandom_range(0, 3)) v[$urandom_range(0, DW + PW)] ^= 1'b1;
      if ($urandom_range(9) == 0) v = (DW+PW+1)'($urandom);
      {a, p, d} = v;
      send(d, p, a, ref_dec(d, p, a), 70);
      if ($urandom_range(3) == 0) idle($urandom_range(1, 3), 60, 3);
    end
    drain();
    // stall: four words offered while downstream is blocked
    accepted = 0;
    repeat (5) begin
      d = DW'(accepted * 37 + 5);
      enc(d, p, a);
      step(1, d, p, a, 0, 0, ref_dec(d, p, a), acc);
      if (acc) accepted++;
    end
    chk("stall_accepted", accepted, 2);
    chk("stall_oready", o_ready, 0);
    while (accepted < 4) begin
      d = DW'(accepted * 37 + 5);
      enc(d, p, a);
      send(d, p, a, ref_dec(d, p, a), 100);
      accepted++;
    end
    drain();
    // counter saturation then clear coinciding with a delivery
    sbe_w = '{d: 10'h000, sbe: 1, dbe: 0, pos: 3};
    repeat (5) send(10'h001, 4'h0, 0, sbe_w, 100);
    drain();
`ifdef HAMMING_ECC_ERR_CNT_EN
    chk("sbe_cnt_sat", o_sbe_cnt, CMAX);
`else
    chk("sbe_cnt_tied", o_sbe_cnt, 0);
`endif
    send(10'h001, 4'h0, 0, sbe_w, 100);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      i_valid = 0; i_ready = 1; i_clr_cnt = o_valid;
      #1 if (i_clr_cnt) break;
    end
    chk("clr_aligned", i_clr_cnt, 1);
    idle(2, 100, 0);
    chk("sbe_cnt_cleared", o_sbe_cnt, 0);
    drain();
    // asynchronous reset in the middle of a stream
    for (int n = 0; n < 3; n++) begin
      d = DW'($urandom);
      enc(d, p, a);
      send(d, p, a, ref_dec(d, p, a), 100);
    end
    chk("pre_rst_ovalid", o_valid, 1);
    #2 rst_n = 0;
    q.delete();
    #1;
    chk("midrst_ovalid", o_valid, 0);
    chk("midrst_oready", o_ready, 1);
    chk("midrst_fields", {o_data, o_sbe, o_dbe, o_err_pos}, 0);
    idle(2, 100, 0);
    @(negedge clk); #3 rst_n = 1;
    idle(3, 100, 0);
    chk("post_rst_ovalid", o_valid, 0);
    send(10'h001, 4'h0, 0, sbe_w, 100);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
